pipe_fetch_queue: RTL and testbench
===================================

Name: pipe_fetch_queue

Overview:
Instruction fetch queue between the PC/instruction-memory stage (IF) and decode (ID).
- Buffers up to DEPTH fetched {pc+4, instruction} pairs.
- Drives the PC load enable, so the PC holds when the queue is full.
- Presents the head entry to decode.
- Discards everything on a branch/jump redirect (flush).

Parameters:
DEPTH, 4, number of entries; power of two, >= 2.
AW, 2, pointer width; must equal log2(DEPTH).

Ports:
clk  input  1  pipeline clock; all state changes on rising edge.
clrn  input  1  synchronous, active-high clear. The name is kept for consistency with the pipeline registers; 1 = clear on the next rising edge.
if_valid  input  1  IF presents a fetched instruction this cycle.
if_pc4  input  32  PC+4 of the fetched instruction.
if_inst  input  32  fetched instruction word.
pc_en  output  1  PC load enable to the PC register; 1 = PC may advance.
id_ready  input  1  ID consumes the head entry this cycle.
id_valid  output  1  head entry valid.
id_pc4  output  32  head PC+4.
id_inst  output  32  head instruction.
flush  input  1  redirect from ID/EX; kill all queued and incoming entries.
count  output  AW+1  current occupancy, 0..DEPTH.
ovf  output  1  sticky error: a push was attempted while full.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous, active-high (clrn=1 at a rising edge).
- Reset values:
  - count=0, read/write pointers=0, ovf=0.
  - pc_en=1, id_valid=0, id_pc4=0, id_inst=32'h0000_0000 (NOP).
  - Storage contents are don't-care.
- Derived signals (combinational from registered state):
  - full = (count==DEPTH); empty = (count==0).
  - pc_en = !full.
  - id_valid = !empty.
  - id_pc4/id_inst = entry at read pointer when !empty, else 0 / NOP.
- Push: push = if_valid & !full & !flush. Writes if_pc4/if_inst at the write pointer; write pointer +1 mod DEPTH.
- Pop: pop = id_valid & id_ready & !flush. Read pointer +1 mod DEPTH.
- Occupancy update:
  - push & pop: count unchanged.
  - push only: count +1.
  - pop only: count -1.
- Latency: an entry pushed at edge N appears on id_* after edge N (cycle N+1). There is no IF-to-ID bypass, even when the queue is empty.
- Full: push is blocked even if a pop occurs in the same cycle. pc_en=0 in that cycle, so upstream holds the PC and re-presents the same instruction next cycle.
- if_valid=1 while full:
  - Entry dropped, state unchanged.
  - ovf set to 1 and held until clrn.
  - A correct upstream never does this.
- Empty: id_ready is ignored (no underflow); count stays 0.
- Flush:
  - At the next edge, count=0 and both pointers=0.
  - The same-cycle if_valid entry is discarded; the same-cycle pop is suppressed.
  - ovf is not cleared.
  - One cycle after flush, id_valid=0 and pc_en=1.
- clrn priority: clrn > flush > push/pop. clrn mid-operation discards all entries.
- Wrap-around: pointers are AW bits and wrap naturally. count is AW+1 bits so it can distinguish full from empty.

Decomposition:
- Shared pipeline package holds:
  - INST_NOP = 32'h0000_0000.
  - Instruction/PC width constant = 32.
  - Default queue depth = 4.
- No sub-module: storage is a plain DEPTH x 64-bit register array inside the block. Pointer/count logic stays local.

Test Plan:
- Reset: clrn=1 for 2 cycles -> count=0, pc_en=1, id_valid=0, id_inst=0, ovf=0.
- Fill: if_valid=1 for 4 cycles with pc4=0x4,0x8,0xC,0x10, id_ready=0 -> count=4, pc_en=0. id_pc4=0x4 from the cycle after the first push.
- Drain in order: then if_valid=0, id_ready=1 -> id_pc4 reads 0x4,0x8,0xC,0x10 on consecutive cycles, then id_valid=0, count=0.
- Steady state and wrap: if_valid=1, id_ready=1 for 10 cycles with incrementing pc4 -> count stays 1 after the first push; outputs in order with one-cycle latency; pointers wrap with no loss.
- Flush: count=3, assert flush with if_valid=1 (pc4=0x40) -> next cycle count=0, id_valid=0, pc_en=1; 0x40 never appears on id_pc4.
- Overflow and full-with-pop: count=4, if_valid=1, id_ready=1 -> count=3, no push, ovf=1; ovf remains 1 after a later flush and clears only on clrn=1.

Source files
------------

// File: rtl/pipe_fetch_queue_pkg.sv
// pipe_fetch_queue_pkg: shared pipeline constants for the fetch queue.
package pipe_fetch_queue_pkg;
   localparam int XLEN = 32;
   localparam int DEF_DEPTH = 4;
   localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0000;
endpackage

// File: rtl/pipe_fetch_queue.sv
// pipe_fetch_queue: IF->ID instruction queue with PC hold, flush and sticky overflow flag.
module pipe_fetch_queue
   import pipe_fetch_queue_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            clrn,
   input  logic            if_valid,
   input  logic [XLEN-1:0] if_pc4,
   input  logic [XLEN-1:0] if_inst,
   output logic            pc_en,
   input  logic            id_ready,
   output logic            id_valid,
   output logic [XLEN-1:0] id_pc4,
   output logic [XLEN-1:0] id_inst,
   input  logic            flush,
   output logic [AW:0]     count,
   output logic            ovf
);
   logic [2*XLEN-1:0] mem_q [DEPTH];
   logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [AW:0] cnt_q, cnt_d;
   logic ovf_q, ovf_d;
   logic full, empty, push, pop;
   assign full = cnt_q == (AW+1)'(DEPTH);
   assign empty = cnt_q == '0;
   always_comb begin
      push = if_valid & ~full & ~flush;
      pop = ~empty & id_ready & ~flush;
      wp_d = flush ? '0 : wp_q + AW'(push);
      rp_d = flush ? '0 : rp_q + AW'(pop);
      cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      ovf_d = ovf_q | (if_valid & full & ~flush);
   end
   always_ff @(posedge clk) begin
      if (clrn) begin
         wp_q <= '0;
         rp_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end
   // storage needs no reset: it is only observed through a non-empty count
   always_ff @(posedge clk)
      if (!clrn && push) mem_q[wp_q] <= {if_pc4, if_inst};
   assign pc_en = ~full;
   assign id_valid = ~empty;
   assign id_pc4 = empty ? '0 : mem_q[rp_q][2*XLEN-1:XLEN];
   assign id_inst = empty ? INST_NOP : mem_q[rp_q][XLEN-1:0];
   assign count = cnt_q;
   assign ovf = ovf_q;
endmodule

// File: tb/tb_pipe_fetch_queue.sv
// tb_pipe_fetch_queue: directed and randomized checks against a queue-based reference model.
module tb_pipe_fetch_queue;
   localparam int DEPTH = 4;
   logic clk = 1'b0, clrn = 1'b0, if_valid = 1'b0, id_ready = 1'b0, flush = 1'b0;
   logic [31:0] if_pc4 = '0, if_inst = '0;
   logic pc_en, id_valid, ovf;
   logic [31:0] id_pc4, id_inst;
   logic [2:0] count;
   int errors = 0, checks = 0;
   logic [63:0] mq[$];
   logic m_ovf = 1'b0;

   pipe_fetch_queue #(.DEPTH(DEPTH), .AW(2)) dut (
      .clk(clk), .clrn(clrn), .if_valid(if_valid), .if_pc4(if_pc4), .if_inst(if_inst),
      .pc_en(pc_en), .id_ready(id_ready), .id_valid(id_valid), .id_pc4(id_pc4),
      .id_inst(id_inst), .flush(flush), .count(count), .ovf(ovf)
   );

   always #5 clk = ~clk;

   wire [69:0] got = {pc_en, id_valid, id_pc4, id_inst, count, ovf};

   function automatic logic [69:0] exp_vec();
      logic [63:0] h;
      h = mq.size() > 0 ? mq[0] : 64'h0;
      return {mq.size() < DEPTH, mq.size() > 0, h, 3'(mq.size()), m_ovf};
   endfunction

   // model update from the inputs held during the cycle, then advance one edge
   task automatic tick();
      bit was_full;
      if (clrn) begin
         mq.delete();
         m_ovf = 1'b0;
      end else if (flush) begin
         mq.delete();
      end else begin
         was_full = mq.size() == DEPTH;
         if (if_valid && was_full) m_ovf = 1'b1;
         if (id_ready && mq.size() > 0) void'(mq.pop_front());
         if (if_valid && !was_full) mq.push_back({if_pc4, if_inst});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      clrn = 0; flush = 0; if_valid = 0; id_ready = 0;
   endtask

   task automatic test_reset();
      clrn = 1;
      tick();
      tick();
      clrn = 0;
      checks++;
      if (got !== exp_vec()) begin
         errors++;
         $display("FAIL reset got=%h exp=%h", got, exp_vec());
      end
      checks++;
      if ({count, pc_en, id_valid, id_inst, ovf} !== {3'd0, 1'b1, 1'b0, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL reset_const count=%0d pc_en=%b id_valid=%b id_inst=%h ovf=%b", count, pc_en, id_valid, id_inst, ovf);
      end
   endtask

   task automatic test_fill();
      idle();
      for (int i = 1; i <= 4; i++) begin
         if_valid = 1; if_pc4 = 32'(4 * i); if_inst = 32'h1000 + 32'(i);
         tick();
         checks++;
         if (got !== exp_vec()) begin
            errors++;
            $display("FAIL fill[%0d] got=%h exp=%h", i, got, exp_vec());
         end
         checks++;
         if (id_pc4 !== 32'h4 || id_valid !== 1'b1) begin
            errors++;
            $display("FAIL fill_head[%0d] id_pc4=%h id_valid=%b exp 4/1", i, id_pc4, id_valid);
         end
      end
      if_valid = 0;
      checks++;
      if (count !== 3'd4 || pc_en !== 1'b0) begin
         errors++;
         $display("FAIL fill_full count=%0d pc_en=%b exp 4/0", count, pc_en);
      end
   endtask

   task automatic test_drain();
      idle();
      id_ready = 1;
      for (int i = 1; i <= 4; i++) begin
         checks++;
         if (id_pc4 !== 32'(4 * i) || id_inst !== 32'h1000 + 32'(i)) begin
            errors++;
            $display("FAIL drain[%0d] id_pc4=%h id_inst=%h exp %h", i, id_pc4, id_inst, 4 * i);
         end
         tick();
      end
      tick();
      checks++;
      if (got !== exp_vec() || id_valid !== 1'b0 || count !== 3'd0) begin
         errors++;
         $display("FAIL drain_empty got=%h exp=%h", got, exp_vec());
      end
   endtask

   task automatic test_back_to_back();
      idle();
      if_valid = 1; id_ready = 1;
      for (int i = 0; i < 10; i++) begin
         if_pc4 = 32'h100 + 32'(4 * i); if_inst = 32'hA0 + 32'(i);
         tick();
         checks++;
         if (got !== exp_vec() || count !== 3'd1 || id_pc4 !== 32'h100 + 32'(4 * i)) begin
            errors++;
            $display("FAIL steady[%0d] got=%h exp=%h", i, got, exp_vec());
         end
      end
      idle();
      id_ready = 1;
      tick();
   endtask

   task automatic test_flush();
      idle();
      for (int i = 0; i < 3; i++) begin
         if_valid = 1; if_pc4 = 32'h20 + 32'(4 * i); if_inst = 32'hB0 + 32'(i);
         tick();
      end
      checks++;
      if (count !== 3'd3) begin
         errors++;
         $display("FAIL flush_pre count=%0d exp 3", count);
      end
      flush = 1; if_valid = 1; id_ready = 1; if_pc4 = 32'h40; if_inst = 32'hDEAD;
      tick();
      idle();
      checks++;
      if (got !== exp_vec() || count !== 3'd0 || id_valid !== 1'b0 || pc_en !== 1'b1) begin
         errors++;
         $display("FAIL flush got=%h exp=%h", got, exp_vec());
      end
      for (int i = 0; i < 3; i++) begin
         id_ready = 1;
         tick();
         checks++;
         if (id_pc4 === 32'h40 || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_leak[%0d] id_pc4=%h id_valid=%b exp 0/0", i, id_pc4, id_valid);
         end
      end
   endtask

   task automatic test_overflow();
      idle();
      for (int i = 0; i < 4; i++) begin
         if_valid = 1; if_pc4 = 32'h80 + 32'(4 * i); if_inst = 32'hC0 + 32'(i);
         tick();
      end
      if_valid = 1; id_ready = 1; if_pc4 = 32'h90; if_inst = 32'hC4;
      tick();
      idle();
      checks++;
      if (got !== exp_vec() || count !== 3'd3 || ovf !== 1'b1 || id_pc4 !== 32'h84) begin
         errors++;
         $display("FAIL ovf got=%h exp=%h", got, exp_vec());
      end
      flush = 1;
      tick();
      idle();
      checks++;
      if (ovf !== 1'b1 || count !== 3'd0) begin
         errors++;
         $display("FAIL ovf_sticky ovf=%b count=%0d exp 1/0", ovf, count);
      end
      clrn = 1;
      tick();
      idle();
      checks++;
      if (ovf !== 1'b0 || got !== exp_vec()) begin
         errors++;
         $display("FAIL ovf_clear ovf=%b got=%h exp=%h", ovf, got, exp_vec());
      end
   endtask

   task automatic test_random();
      int fails = 0;
      idle();
      for (int i = 0; i < 400; i++) begin
         clrn = $urandom_range(0, 49) == 0;
         flush = $urandom_range(0, 14) == 0;
         if_valid = $urandom_range(0, 2) != 0;
         if (flush && mq.size() == DEPTH) if_valid = 0;
         id_ready = $urandom_range(0, 1) == 1;
         if_pc4 = $urandom; if_inst = $urandom;
         tick();
         checks++;
         if (got !== exp_vec()) begin
            errors++;
            if (fails++ < 10) $display("FAIL random[%0d] got=%h exp=%h", i, got, exp_vec());
         end
      end
      idle();
   endtask

   initial begin
      #1;
      test_reset();
      test_fill();
      test_drain();
      test_back_to_back();
      test_flush();
      test_overflow();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
